// File: rtl/mux_32to1_pkg.sv
// Shared constants and the data word type for the registered 32-way word multiplexer.
package mux_32to1_pkg;

    localparam int NUM_INPUTS = 32;
    localparam int SEL_W      = 5;
    localparam int DATA_W     = 32;

    typedef logic [DATA_W-1:0] data_word_t;

endpackage

// File: rtl/mux_32to1.sv
// Registered 32-way word multiplexer: Out takes Input[Select] one Clk edge later.
// Define MUX32TO1_HOLD_EN to add an Enable input that freezes Out while low.
module mux_32to1
    import mux_32to1_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             Clk,
    input  logic             Resetn,
    input  logic [SEL_W-1:0] Select,
    input  logic [WIDTH-1:0] Input0,
    input  logic [WIDTH-1:0] Input1,
    input  logic [WIDTH-1:0] Input2,
    input  logic [WIDTH-1:0] Input3,
    input  logic [WIDTH-1:0] Input4,
    input  logic [WIDTH-1:0] Input5,
    input  logic [WIDTH-1:0] Input6,
    input  logic [WIDTH-1:0] Input7,
    input  logic [WIDTH-1:0] Input8,
    input  logic [WIDTH-1:0] Input9,
    input  logic [WIDTH-1:0] Input10,
    input  logic [WIDTH-1:0] Input11,
    input  logic [WIDTH-1:0] Input12,
    input  logic [WIDTH-1:0] Input13,
    input  logic [WIDTH-1:0] Input14,
    input  logic [WIDTH-1:0] Input15,
    input  logic [WIDTH-1:0] Input16,
    input  logic [WIDTH-1:0] Input17,
    input  logic [WIDTH-1:0] Input18,
    input  logic [WIDTH-1:0] Input19,
    input  logic [WIDTH-1:0] Input20,
    input  logic [WIDTH-1:0] Input21,
    input  logic [WIDTH-1:0] Input22,
    input  logic [WIDTH-1:0] Input23,
    input  logic [WIDTH-1:0] Input24,
    input  logic [WIDTH-1:0] Input25,
    input  logic [WIDTH-1:0] Input26,
    input  logic [WIDTH-1:0] Input27,
    input  logic [WIDTH-1:0] Input28,
    input  logic [WIDTH-1:0] Input29,
    input  logic [WIDTH-1:0] Input30,
    input  logic [WIDTH-1:0] Input31,
`ifdef MUX32TO1_HOLD_EN
    input  logic             Enable,
`endif
    output logic [WIDTH-1:0] Out
);

    logic [WIDTH-1:0] sel_word;
    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] out_q;

    always_comb begin
        sel_word = '0;
        case (Select)
            5'd0:  sel_word = Input0;
            5'd1:  sel_word = Input1;
            5'd2:  sel_word = Input2;
            5'd3:  sel_word = Input3;
            5'd4:  sel_word = Input4;
            5'd5:  sel_word = Input5;
            5'd6:  sel_word = Input6;
            5'd7:  sel_word = Input7;
            5'd8:  sel_word = Input8;
            5'd9:  sel_word = Input9;
            5'd10: sel_word = Input10;
            5'd11: sel_word = Input11;
            5'd12: sel_word = Input12;
            5'd13: sel_word = Input13;
            5'd14: sel_word = Input14;
            5'd15: sel_word = Input15;
            5'd16: sel_word = Input16;
            5'd17: sel_word = Input17;
            5'd18: sel_word = Input18;
            5'd19: sel_word = Input19;
            5'd20: sel_word = Input20;
            5'd21: sel_word = Input21;
            5'd22: sel_word = Input22;
            5'd23: sel_word = Input23;
            5'd24: sel_word = Input24;
            5'd25: sel_word = Input25;
            5'd26: sel_word = Input26;
            5'd27: sel_word = Input27;
            5'd28: sel_word = Input28;
            5'd29: sel_word = Input29;
            5'd30: sel_word = Input30;
            5'd31: sel_word = Input31;
        endcase
    end

    // With the hold option, a deasserted Enable recirculates the current output.
    always_comb begin
        out_d = sel_word;
`ifdef MUX32TO1_HOLD_EN
        if (!Enable) begin
            out_d = out_q;
        end
`endif
    end

    always_ff @(posedge Clk) begin
        if (!Resetn) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign Out = out_q;

endmodule

// File: tb/tb_mux_32to1.sv
// Scoreboard bench for mux_32to1: directed vectors push expected words, a monitor checks Out.
// Covers the MUX32TO1_HOLD_EN hold behaviour when that macro is defined.
module tb_mux_32to1;

    logic        clk;
    logic        resetn;
    logic [4:0]  sel;
    logic [31:0] in_vals [32];
    logic [31:0] out;
`ifdef MUX32TO1_HOLD_EN
    logic        enable;
`endif

    typedef struct {
        logic [31:0] exp;
        int          tag;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    int total;
    int bad;
    int tag_cnt;

    mux_32to1 #(.WIDTH(32)) dut (
        .Clk(clk),
        .Resetn(resetn),
        .Select(sel),
        .Input0(in_vals[0]),
        .Input1(in_vals[1]),
        .Input2(in_vals[2]),
        .Input3(in_vals[3]),
        .Input4(in_vals[4]),
        .Input5(in_vals[5]),
        .Input6(in_vals[6]),
        .Input7(in_vals[7]),
        .Input8(in_vals[8]),
        .Input9(in_vals[9]),
        .Input10(in_vals[10]),
        .Input11(in_vals[11]),
        .Input12(in_vals[12]),
        .Input13(in_vals[13]),
        .Input14(in_vals[14]),
        .Input15(in_vals[15]),
        .Input16(in_vals[16]),
        .Input17(in_vals[17]),
        .Input18(in_vals[18]),
        .Input19(in_vals[19]),
        .Input20(in_vals[20]),
        .Input21(in_vals[21]),
        .Input22(in_vals[22]),
        .Input23(in_vals[23]),
        .Input24(in_vals[24]),
        .Input25(in_vals[25]),
        .Input26(in_vals[26]),
        .Input27(in_vals[27]),
        .Input28(in_vals[28]),
        .Input29(in_vals[29]),
        .Input30(in_vals[30]),
        .Input31(in_vals[31]),
`ifdef MUX32TO1_HOLD_EN
        .Enable(enable),
`endif
        .Out(out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive on the falling edge; the word expected after the next rising edge goes to the scoreboard.
    task automatic applyStimulus(input logic rn, input logic [4:0] s, input logic [31:0] exp);
        @(negedge clk);
        resetn = rn;
        sel    = s;
        sb_q.push_back('{exp: exp, tag: tag_cnt});
        tag_cnt++;
    endtask

    task automatic checkOutput(input sb_entry_t e);
        total++;
        if (out !== e.exp) begin
            bad++;
            $display("[TB] FAIL check#%0d out actual=%h expected=%h", e.tag, out, e.exp);
        end
    endtask

    // Monitor: Out is presented every cycle, so each rising edge retires one pending expectation.
    initial begin
        sb_entry_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation time limit expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        total   = 0;
        bad     = 0;
        tag_cnt = 0;
        resetn  = 1'b0;
        sel     = 5'd0;
        for (int i = 0; i < 32; i++) in_vals[i] = 32'h0;
`ifdef MUX32TO1_HOLD_EN
        enable = 1'b1;
`endif

        // Held in reset with a live selected input.
        in_vals[2] = 32'h7FFF_FFFF;
        applyStimulus(1'b0, 5'd2, 32'h0);
        applyStimulus(1'b0, 5'd2, 32'h0);

        // Release with zeroed inputs, then raise Input2.
        @(negedge clk);
        in_vals[2] = 32'h0;
        applyStimulus(1'b1, 5'd2, 32'h0);
        @(negedge clk);
        in_vals[2] = 32'h7FFF_FFFF;
        applyStimulus(1'b1, 5'd2, 32'h7FFF_FFFF);

        // Switch away; the old input no longer matters.
        applyStimulus(1'b1, 5'd4, 32'h0);
        @(negedge clk);
        in_vals[2] = 32'h1234_5678;
        applyStimulus(1'b1, 5'd4, 32'h0);

        // Sweep every Select code over a recognisable pattern.
        @(negedge clk);
        for (int n = 0; n < 32; n++) in_vals[n] = n * 32'h0101_0101;
        for (int n = 0; n < 32; n++) begin
            logic [7:0] b;
            b = n[7:0];
            applyStimulus(1'b1, n[4:0], {b, b, b, b});
        end
        applyStimulus(1'b1, 5'd0, 32'h0000_0000);
        applyStimulus(1'b1, 5'd31, 32'h1F1F_1F1F);

        // Unselected inputs toggling leave Out alone.
        applyStimulus(1'b1, 5'd5, 32'h0505_0505);
        @(negedge clk);
        in_vals[0]  = 32'hFFFF_FFFF;
        in_vals[31] = 32'hCAFE_F00D;
        applyStimulus(1'b1, 5'd5, 32'h0505_0505);

        // Select and its data change together.
        @(negedge clk);
        in_vals[7] = 32'hDEAD_BEEF;
        applyStimulus(1'b1, 5'd7, 32'hDEAD_BEEF);

        // Mid-stream reset pulse.
        @(negedge clk);
        in_vals[31] = 32'h1F1F_1F1F;
        applyStimulus(1'b1, 5'd31, 32'h1F1F_1F1F);
        applyStimulus(1'b0, 5'd31, 32'h0);
        applyStimulus(1'b1, 5'd31, 32'h1F1F_1F1F);

`ifdef MUX32TO1_HOLD_EN
        @(negedge clk);
        in_vals[3] = 32'hAAAA_AAAA;
        in_vals[4] = 32'h5555_5555;
        applyStimulus(1'b1, 5'd3, 32'hAAAA_AAAA);
        @(negedge clk);
        enable = 1'b0;
        applyStimulus(1'b1, 5'd4, 32'hAAAA_AAAA);
        @(negedge clk);
        in_vals[3] = 32'h0F0F_0F0F;
        applyStimulus(1'b1, 5'd3, 32'hAAAA_AAAA);
        @(negedge clk);
        enable = 1'b1;
        applyStimulus(1'b1, 5'd4, 32'h5555_5555);
        @(negedge clk);
        enable = 1'b0;
        applyStimulus(1'b0, 5'd4, 32'h0);
        applyStimulus(1'b1, 5'd3, 32'h0);
        @(negedge clk);
        enable = 1'b1;
        applyStimulus(1'b1, 5'd3, 32'h0F0F_0F0F);
`endif

        @(posedge clk);
        #2;
        @(posedge clk);
        #2;
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL drain pending actual=%0d required=0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
